// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-through, no-write-allocate byte cache with req/ack memory port
module cache_controller #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS = 32 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [7:0]  cpu_rdata,
  output logic [31:0] Address,
  output logic [7:0]  Data,
  output logic        ismemWrite,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  outputmem,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  typedef enum logic [2:0] {IDLE, COMPARE, MEM_READ, MEM_WRITE, RESP} state_t;
  state_t state;
  logic [7:0] data_a [2**INDEX_BITS];
  logic [TAG_BITS-1:0] tag_a [2**INDEX_BITS];
  logic [2**INDEX_BITS-1:0] valid;
  logic write_q;
  logic [INDEX_BITS-1:0] idx;
  logic hit;
  // Address/Data double as the latched request, so they hold between transactions
  assign idx = Address[INDEX_BITS-1:0];
  assign hit = valid[idx] && tag_a[idx] == Address[31:INDEX_BITS];
  assign cpu_ready = state == IDLE;
  assign cpu_done = state == RESP;
  assign mem_req = state == MEM_READ || state == MEM_WRITE;
  assign ismemWrite = state == MEM_WRITE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      hit_count <= '0;
      miss_count <= '0;
      cpu_rdata <= '0;
      Address <= '0;
      Data <= '0;
      write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cpu_valid) begin
          Address <= cpu_addr;
          Data <= cpu_wdata;
          write_q <= cpu_write;
          state <= COMPARE;
        end
        COMPARE: begin
          if (hit) hit_count <= hit_count + 16'(hit_count != 16'hFFFF);
          else miss_count <= miss_count + 16'(miss_count != 16'hFFFF);
          if (write_q) begin
            cpu_rdata <= Data;
            state <= MEM_WRITE;
          end else if (hit) begin
            cpu_rdata <= data_a[idx];
            state <= RESP;
          end else state <= MEM_READ;
        end
        MEM_READ: if (mem_ack) begin
          cpu_rdata <= outputmem;
          valid[idx] <= 1'b1;
          state <= RESP;
        end
        MEM_WRITE: if (mem_ack) state <= RESP;
        default: state <= IDLE;
      endcase
    end
  // data/tag arrays carry no reset; validity alone decides a hit
  always_ff @(posedge clk)
    if (state == COMPARE && write_q && hit) data_a[idx] <= Data;
    else if (state == MEM_READ && mem_ack) begin
      data_a[idx] <= outputmem;
      tag_a[idx] <= Address[31:INDEX_BITS];
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed plus randomized checks against a line-level cache and memory model
module tb_cache_controller;
  logic clk = 0, reset = 1;
  logic cpu_valid = 0, cpu_write = 0, mem_ack = 0;
  logic [31:0] cpu_addr = 0;
  logic [7:0] cpu_wdata = 0, outputmem = 0;
  logic cpu_ready, cpu_done, ismemWrite, mem_req;
  logic [7:0] cpu_rdata, Data;
  logic [31:0] Address;
  logic [15:0] hit_count, miss_count;
  int checks = 0, errors = 0;
  logic mvalid [16];
  logic [31:0] maddr [16];
  logic [7:0] mdata [16];
  logic [7:0] mem [logic [31:0]];
  int hits = 0, misses = 0;

  cache_controller dut (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .Address(Address), .Data(Data),
    .ismemWrite(ismemWrite), .mem_req(mem_req), .mem_ack(mem_ack),
    .outputmem(outputmem), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [7:0] memv(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mvalid[i] = 0;
    hits = 0;
    misses = 0;
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [7:0] d, input int dly);
    int li, lat, cyc, reqc;
    bit h, saw;
    logic [7:0] exp_rd, fill;
    li = int'(a[3:0]);
    h = mvalid[li] && maddr[li] == a;
    lat = (!w && h) ? 2 : 3 + dly;
    fill = memv(a);
    exp_rd = w ? d : (h ? mdata[li] : fill);
    if (h) hits = hits < 65535 ? hits + 1 : hits;
    else misses = misses < 65535 ? misses + 1 : misses;
    if (w) begin
      if (h) mdata[li] = d;
      mem[a] = d;
    end else if (!h) begin
      mvalid[li] = 1;
      maddr[li] = a;
      mdata[li] = fill;
    end
    cyc = 0;
    while (!cpu_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_before_req", cpu_ready, 1);
    cpu_valid = 1;
    cpu_write = w;
    cpu_addr = a;
    cpu_wdata = d;
    @(negedge clk);
    cpu_valid = 0;
    cpu_addr = $urandom;
    cpu_wdata = 8'($urandom);
    mem_ack = 1'($urandom);
    outputmem = 8'($urandom);
    cyc = 1;
    reqc = 0;
    saw = 0;
    while (!cpu_done && cyc < 40) begin
      if (cyc > 1) mem_ack = 0;
      if (mem_req) begin
        saw = 1;
        chk("req_address", Address, a);
        chk("req_iswrite", ismemWrite, w);
        if (w) chk("req_data", Data, d);
        if (reqc == dly) begin
          mem_ack = 1;
          outputmem = fill;
        end else outputmem = 8'($urandom);
        reqc++;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 0;
    chk("latency", cyc, lat);
    chk("mem_access", saw, !(!w && h));
    chk("rdata", cpu_rdata, exp_rd);
    chk("hit_count", hit_count, hits);
    chk("miss_count", miss_count, misses);
    @(negedge clk);
    chk("done_one_cycle", cpu_done, 0);
    chk("ready_after_resp", cpu_ready, 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", cpu_ready, 1);
    chk("rst_done", cpu_done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_iswrite", ismemWrite, 0);
    chk("rst_addr", Address, 0);
    chk("rst_data", Data, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    reset = 0;
    @(negedge clk);
    xact(0, 32'h13, 0, 0);
    xact(0, 32'h13, 0, 0);
    xact(1, 32'h13, 8'hA5, 1);
    xact(0, 32'h13, 0, 0);
    xact(1, 32'h24, 8'h77, 0);
    xact(0, 32'h24, 0, 2);
    xact(0, 32'h113, 0, 0);
    xact(0, 32'h13, 0, 1);
    xact(0, 32'h113, 0, 0);
    // abandon a read miss while memory is still holding off its ack
    cpu_valid = 1;
    cpu_write = 0;
    cpu_addr = 32'h55;
    @(negedge clk);
    cpu_valid = 0;
    @(negedge clk);
    chk("rst_mid_req_up", mem_req, 1);
    #2 reset = 1;
    #1;
    chk("rst_mid_req_drop", mem_req, 0);
    chk("rst_mid_done", cpu_done, 0);
    chk("rst_mid_hits", hit_count, 0);
    chk("rst_mid_misses", miss_count, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    mem_ack = 1;
    outputmem = 8'hEE;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_done", cpu_done, 0);
      chk("post_rst_no_req", mem_req, 0);
    end
    mem_ack = 0;
    xact(0, 32'h55, 0, 0);
    xact(0, 32'h55, 0, 0);
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hF000_030F)
                                       : 32'(($urandom_range(0, 3) << 8) | $urandom_range(0, 15));
      xact($urandom_range(0, 2) == 0, a, 8'($urandom), $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through, no-write-allocate byte cache between the CPU request port and `MainMemory`. It issues `Address`/`Data`/`ismemWrite` transactions with a req/ack handshake and returns read bytes to the CPU. Hits are served locally and misses fill one line from memory. It keeps saturating hit/miss counters for performance checks.

## Interface
- `INDEX_BITS`, 4: line index width; the cache holds 2**INDEX_BITS one-byte lines.
- `TAG_BITS`, 32-INDEX_BITS: stored tag width (Address[31:INDEX_BITS]).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_valid`  in  1  CPU request present.
- `cpu_write`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  8  write byte.
- `cpu_ready`  out  1  controller can accept a request (IDLE).
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  8  read result, valid while cpu_done=1.
- `Address`  out  32  memory address.
- `Data`  out  8  memory write byte.
- `ismemWrite`  out  1  memory op type.
- `mem_req`  out  1  memory request, held until ack.
- `mem_ack`  in  1  memory completion; read byte valid on `outputmem`.
- `outputmem`  in  8  memory read byte.
- `hit_count`  out  16  saturating hit counter.
- `miss_count`  out  16  saturating miss counter.

## Operation
- States: IDLE, COMPARE, MEM_READ, MEM_WRITE, RESP.
- IDLE: cpu_ready=1. On `cpu_valid`, latch addr, write, and wdata, then go to COMPARE. `cpu_valid` outside IDLE is ignored.
- COMPARE: index = addr[INDEX_BITS-1:0]. Hit = valid[index] && tag[index]==addr[31:INDEX_BITS].
  - Read hit: rdata <= data[index]; hit_count++; go to RESP.
  - Read miss: miss_count++; go to MEM_READ.
  - Write hit: data[index] <= wdata; hit_count++; go to MEM_WRITE.
  - Write miss: miss_count++; go to MEM_WRITE. The line is not allocated and the cache is unchanged.
- MEM_READ: mem_req=1, ismemWrite=0, Address=latched addr. On an edge with mem_ack=1:
  - data[index] <= outputmem; tag[index] <= addr tag; valid[index] <= 1; rdata <= outputmem.
  - Go to RESP.
- MEM_WRITE: mem_req=1, ismemWrite=1, Address=latched addr, Data=wdata. On mem_ack, go to RESP.
- RESP: cpu_done=1 for exactly one cycle, cpu_rdata holds rdata, then go to IDLE. For writes, cpu_rdata = wdata.
- Outside MEM_* states: mem_req=0, ismemWrite=0. Address/Data hold the last latched values.
- mem_ack while mem_req=0 is ignored.
- Counters saturate at 16'hFFFF and do not wrap.
- Conflicting read miss overwrites the resident line. No writeback is needed because the cache is write-through.

## Timing
- Reset (async assert, any state): state=IDLE, all valid bits=0, hit_count=miss_count=0, cpu_done=0, cpu_rdata=0, mem_req=0, ismemWrite=0, Address=0, Data=0.
  - The data/tag arrays are not reset.
  - An in-flight memory transaction is abandoned: mem_req drops immediately with reset and no fill occurs.
- Acceptance edge = cycle 0.
  - COMPARE in cycle 1.
  - Read hit: cpu_done high in cycle 2.
- Miss or write:
  - mem_req rises in cycle 2.
  - If mem_ack is sampled high at the end of cycle k (k≥2), cpu_done is high in cycle k+1.
  - Minimum latency is 3 cycles from acceptance to done (ack in cycle 2).
- mem_req, Address, Data, and ismemWrite are stable from request until the ack edge.
- Back-to-back: cpu_ready returns in the cycle after RESP. The next request can be accepted then.
- Counters update on the COMPARE→next edge. They are visible from cycle 2.

## Test plan
- Cold read: after reset, read 0x0000_0013 with memory acking on its first mem_req cycle and outputmem=0x13 → Address=0x13, ismemWrite=0, cpu_done in cycle 3, cpu_rdata=0x13, miss_count=1.
- Read hit: repeat the read of 0x13 → no mem_req, cpu_done in cycle 2, cpu_rdata=0x13, hit_count=1.
- Write hit: write 0xA5 to 0x13 → mem_req with ismemWrite=1, Data=0xA5. A following read of 0x13 hits with 0xA5 and no memory access.
- Write miss no-allocate: write 0x77 to 0x24 → memory write issued, miss_count++. A read of 0x24 then misses and issues a memory read.
- Conflict: read 0x13, then 0x113 (same index 3), then 0x13 → three misses, with each fill replacing the line.
- Reset mid-miss: assert reset while mem_req=1 with ack delayed 5 cycles → mem_req=0 immediately, no cpu_done, counters=0. A subsequent read of the same address misses.
